spram_lsu: RTL
==============

# spram_lsu

Byte-addressed load/store sequencer that acts as the initiator for the 32-bit, 32K-word single-port SPRAM block (`spram32_32k`). It accepts byte, halfword and word requests at any byte address from the Forth core. It issues one or two word-wide beats with byte masks, so no read-modify-write is needed. It assembles read data right-aligned and signals completion with a one-cycle `ack`. Byte order is big-endian: byte offset 0 is word bits [31:24].

## Interface
- `AW`, 17: byte-address width (128 KB = 32K words × 4).
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req` in 1: request strobe, sampled only when `busy`=0.
- `we` in 1: 0 = load, 1 = store.
- `sz` in 2: 0 byte, 1 halfword, 2 word; 3 is treated as 2.
- `a` in AW: byte address.
- `vi` in 32: store data, right-aligned; only the low n bytes are used.
- `vo` out 32: load data, right-aligned and zero-extended. Registered; holds until the next load completes.
- `ack` out 1: one-cycle completion pulse.
- `busy` out 1: high from the cycle after acceptance through the FIN state.
- `m_we` out 1: SPRAM write enable.
- `m_bmsk` out 4: SPRAM byte mask; bit 3 is lane [31:24].
- `m_a` out 15: SPRAM word address.
- `m_vi` out 32: SPRAM write data.
- `m_vo` in 32: SPRAM read data, valid the cycle after its address is presented.

## Operation
- Acceptance: `req`=1 while in IDLE latches `we`, n = 1/2/4, word address w = `a`[AW-1:2], and offset off = `a`[1:0].
- Beat count: 2 if off+n > 4, else 1.
- Beat-1 address is w+1 modulo 32K; 0x7FFF wraps to 0x0000.
- Store alignment uses an 8-byte window {word w, word w+1}:
  - data64 = `vi` << 8·(8−off−n);
  - mask8 = ((1<<n)−1) << (8−off−n);
  - beat 0 uses data64[63:32] and mask8[7:4]; beat 1 uses data64[31:0] and mask8[3:0].
- Load: beat-0 data is captured into a hi register; beat-1 data (or zero) forms lo. `vo` = ({hi,lo} >> 8·(8−off−n)) masked to n bytes.
- States:
  - IDLE: waits for `req`; goes to B0 on acceptance.
  - B0: drives beat 0; goes to B1 for a two-beat access, else to FIN.
  - B1: drives beat 1 and captures beat-0 read data; goes to FIN.
  - FIN: captures the last read data and registers `vo` (loads only); goes to IDLE.
- Memory drive:
  - In B0/B1: `m_a`, `m_bmsk`, `m_vi` for the beat; `m_we` = latched `we`.
  - Loads drive `m_bmsk`=4'b1111 with `m_we`=0.
  - In IDLE/FIN: `m_we`=0, `m_bmsk`=0, `m_a` holds its last value.
- `req` while `busy`=1 is ignored, not queued.

## Timing
- Reset values: state IDLE, `ack` 0, `busy` 0, `vo` 0, `m_we` 0, `m_bmsk` 0, `m_a` 0, `m_vi` 0.
- Accepted at edge t: B0 occupies cycle t+1 and FIN occupies cycle t+2; two-beat accesses insert B1, giving FIN at t+3.
- `ack` is high in the cycle after FIN: t+3 for one beat, t+4 for two beats. Loads and stores behave identically.
- `busy`=0 in the `ack` cycle, so a new `req` there is accepted (back-to-back throughput of one access per 3 cycles).
- Store beats are registered outputs; each write commits at the edge ending its B0/B1 cycle.
- Reset mid-operation aborts the access:
  - `m_we`=0 from the next cycle; no further beat is issued;
  - no `ack` is produced; `vo` is cleared;
  - a beat already committed stays written.

## Structure
- `spram_lsu_pkg` contains:
  - the `state_t` enum {IDLE,B0,B1,FIN};
  - the `size_t` enum {SZ_B,SZ_H,SZ_W};
  - function `nbytes(sz)`;
  - function `lane_mask(off,n)` returning 8 bits.
- One combinational sub-module, `spram_lsu_align`, computes data64/mask8 for stores and the extract shift for loads. The top level holds the FSM and registers.
- Wired to `spram32_32k`: `m_*` ports connect to we/bmsk/a/vi/vo.

## Test plan
- Aligned word store `a`=0x00010, `vi`=0x11223344:
  - one beat with `m_a`=4, `m_bmsk`=1111, `m_vi`=0x11223344;
  - `ack` at t+3; word load at 0x10 returns `vo`=0x11223344.
- Byte load `a`=0x00011 after the previous store: `vo`=0x00000022, `ack` at t+3.
- Unaligned word store `a`=0x00013, `vi`=0xAABBCCDD:
  - beat 0: `m_a`=4, `m_bmsk`=0001, `m_vi`[7:0]=AA;
  - beat 1: `m_a`=5, `m_bmsk`=1110, `m_vi`[31:8]=BBCCDD;
  - `ack` at t+4; word load at 0x10 returns 0x112233AA.
- Halfword load at `a`=0x1FFFF, with SPRAM word 0x7FFF = 0x000000EE and word 0 = 0x77000000:
  - beats at `m_a`=0x7FFF then 0x0000 (wrap);
  - `vo`=0x0000EE77.
- Protocol edge cases:
  - `req` held during `busy` is ignored;
  - `req` in the `ack` cycle is accepted;
  - `sz`=3 behaves as word.
- Reset asserted during B1 of a two-beat store: beat 1 is never written, `m_we`=0 next cycle, `ack` stays 0, all outputs take reset values.

Source files
------------

// File: rtl/spram_lsu_pkg.sv
// spram_lsu_pkg: shared types and helpers for the byte-addressed SPRAM
// load/store sequencer.
//   state_t   : sequencer states
//   size_t    : request size encoding (3 falls into the word case)
//   nbytes    : size code -> byte count (1/2/4)
//   lane_mask : 8-lane write mask over the {w, w+1} big-endian window
package spram_lsu_pkg;

  localparam int LSU_AW = 17;  // byte address width
  localparam int WAW    = 15;  // SPRAM word address width

  typedef enum logic [1:0] {IDLE, B0, B1, FIN} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  function automatic logic [2:0] nbytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Lane 7 is byte 0 of word w, lane 0 is byte 3 of word w+1.
  function automatic logic [7:0] lane_mask(input logic [1:0] off, input logic [2:0] n);
    logic [7:0] ones;
    ones = 8'((9'd1 << n) - 9'd1);
    return ones << (4'd8 - 4'(off) - 4'(n));
  endfunction

endpackage

// File: rtl/spram_lsu_if.sv
// spram_lsu_if: core-side request/response and SPRAM-side beat signals.
//   slave  : the sequencer's view (takes requests, drives the SPRAM)
//   master : the core + memory view (issues requests, returns m_vo)
interface spram_lsu_if #(parameter int AW = 17);
  logic          req;
  logic          we;
  logic [1:0]    sz;
  logic [AW-1:0] a;
  logic [31:0]   vi;
  logic [31:0]   vo;
  logic          ack;
  logic          busy;
  logic          m_we;
  logic [3:0]    m_bmsk;
  logic [14:0]   m_a;
  logic [31:0]   m_vi;
  logic [31:0]   m_vo;

  modport slave  (input  req, we, sz, a, vi, m_vo,
                  output vo, ack, busy, m_we, m_bmsk, m_a, m_vi);
  modport master (output req, we, sz, a, vi, m_vo,
                  input  vo, ack, busy, m_we, m_bmsk, m_a, m_vi);
endinterface

// File: rtl/spram_lsu_align.sv
// spram_lsu_align: combinational alignment for one request.
//   off, n  : byte offset in word and byte count
//   vi      : right-aligned store data
//   data64  : store data placed in the {w, w+1} window
//   mask8   : byte lanes touched in that window
//   shamt   : bit shift that right-aligns a load from the same window
module spram_lsu_align
  import spram_lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  n,
  input  logic [31:0] vi,
  output logic [63:0] data64,
  output logic [7:0]  mask8,
  output logic [5:0]  shamt
);
  // off+n never exceeds 7, so the byte shift stays in 1..7.
  logic [2:0] sh_b;
  assign sh_b   = 3'(4'd8 - 4'(off) - 4'(n));
  assign shamt  = {sh_b, 3'b000};
  assign data64 = {32'h0, vi} << shamt;
  assign mask8  = lane_mask(off, n);
endmodule

// File: rtl/spram_lsu.sv
// spram_lsu: byte-addressed load/store sequencer in front of a 32-bit,
// 32K-word single-port SPRAM. Splits any byte/halfword/word access into one
// or two masked word beats; big-endian lane order.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request (req/we/sz/a/vi), response (vo/ack/busy) and
//              SPRAM beat (m_we/m_bmsk/m_a/m_vi, m_vo) signals
module spram_lsu
  import spram_lsu_pkg::*;
#(parameter int AW = LSU_AW)
(
  input logic         clk,
  input logic         rst,
  spram_lsu_if.slave  bus
);
  state_t state, state_n;

  logic           we_q, two_q, m_we_q;
  logic [2:0]     n_q;
  logic [5:0]     sh_q;
  logic [WAW-1:0] w_q;
  logic [31:0]    d1_q, hi_q;
  logic [3:0]     k1_q;

  logic [1:0]     off;
  logic [2:0]     n;
  logic [WAW-1:0] w;
  logic           two;
  logic [63:0]    data64;
  logic [7:0]     mask8;
  logic [5:0]     shamt;
  logic [63:0]    rd64;
  logic [31:0]    bmask, ext;

  assign off = bus.a[1:0];
  assign n   = nbytes(bus.sz);
  assign w   = WAW'(bus.a[AW-1:2]);
  assign two = ({1'b0, off} + n) > 3'd4;

  spram_lsu_align u_align (
    .off    (off),
    .n      (n),
    .vi     (bus.vi),
    .data64 (data64),
    .mask8  (mask8),
    .shamt  (shamt)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.req) state_n = B0;
      B0:      state_n = two_q ? B1 : FIN;
      B1:      state_n = FIN;
      default: state_n = IDLE;
    endcase
  end

  // Final read word arrives in FIN; single-beat loads have no lo half.
  always_comb begin
    rd64  = two_q ? {hi_q, bus.m_vo} : {bus.m_vo, 32'h0};
    bmask = 32'hFFFF_FFFF >> (6'd32 - {n_q, 3'b000});
    ext   = 32'(rd64 >> sh_q) & bmask;
  end

  assign bus.busy = (state != IDLE);
  // Gating with rst keeps a beat from committing on the reset edge itself.
  assign bus.m_we = m_we_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      two_q      <= 1'b0;
      n_q        <= 3'd0;
      sh_q       <= 6'd0;
      w_q        <= '0;
      d1_q       <= 32'h0;
      k1_q       <= 4'h0;
      hi_q       <= 32'h0;
      m_we_q     <= 1'b0;
      bus.vo     <= 32'h0;
      bus.ack    <= 1'b0;
      bus.m_bmsk <= 4'h0;
      bus.m_a    <= '0;
      bus.m_vi   <= 32'h0;
    end else begin
      state   <= state_n;
      bus.ack <= (state == FIN);
      case (state)
        IDLE: if (bus.req) begin
          // Beat 0 is registered straight from the request; beat 1 is parked.
          we_q       <= bus.we;
          two_q      <= two;
          n_q        <= n;
          sh_q       <= shamt;
          w_q        <= w;
          d1_q       <= data64[31:0];
          k1_q       <= mask8[3:0];
          m_we_q     <= bus.we;
          bus.m_a    <= w;
          bus.m_bmsk <= bus.we ? mask8[7:4] : 4'hF;
          bus.m_vi   <= data64[63:32];
        end
        B0: if (two_q) begin
          bus.m_a    <= w_q + 1'b1;  // wraps 0x7FFF -> 0x0000
          bus.m_bmsk <= we_q ? k1_q : 4'hF;
          bus.m_vi   <= d1_q;
        end else begin
          m_we_q     <= 1'b0;
          bus.m_bmsk <= 4'h0;
        end
        B1: begin
          m_we_q     <= 1'b0;
          bus.m_bmsk <= 4'h0;
          hi_q       <= bus.m_vo;
        end
        default: if (!we_q) bus.vo <= ext;
      endcase
    end
  end
endmodule
